// File: rtl/tt_sel_ctrl_if.sv
// Pad-side controls and selector outputs shared by the design selector and its driver.
interface tt_sel_ctrl_if #(
  parameter int G_X = 16,
  parameter int G_Y = 24
);
  localparam int BLK_W  = $clog2(G_X);
  localparam int BR_W   = (G_Y > 1) ? $clog2(G_Y) : 1;
  localparam int ADDR_W = BLK_W + BR_W;

  logic              cfg_serial;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_sel_data;
  logic              ctrl_ena;
  logic [ADDR_W-1:0] sel_addr;
  logic [BLK_W-1:0]  sel_blk;
  logic [G_Y-1:0]    sel_branch_oh;
  logic              um_ena;
  logic              sel_busy;
  logic              sel_ovf;

  modport master (
    output cfg_serial, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_sel_data, ctrl_ena,
    input  sel_addr, sel_blk, sel_branch_oh, um_ena, sel_busy, sel_ovf
  );

  modport slave (
    input  cfg_serial, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_sel_data, ctrl_ena,
    output sel_addr, sel_blk, sel_branch_oh, um_ena, sel_busy, sel_ovf
  );
endinterface

// File: rtl/tt_sel_ctrl.sv
// Pad-driven design selector: pulse-count or serial-load address, one-hot branch, gapped enable.
// Pad edge to sel_addr is SYNC_STAGES+1 clk; um_ena stays low GAP_CYCLES clk after any address change.
module tt_sel_ctrl #(
  parameter int G_X         = 16,
  parameter int G_Y         = 24,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 4
) (
  input  logic          clk,
  input  logic          rst,
  tt_sel_ctrl_if.slave  bus
);
  localparam int BLK_W   = $clog2(G_X);
  localparam int BR_W    = (G_Y > 1) ? $clog2(G_Y) : 1;
  localparam int ADDR_W  = BLK_W + BR_W;
  localparam int N_DES_I = G_X * G_Y;
  localparam logic [ADDR_W:0]   N_DES      = (ADDR_W+1)'(N_DES_I);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N_DES_I - 1);
  localparam int CNT_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  GAP_RELOAD = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_GAP = 2'd1,
    ST_ON  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] rst_n_sync, inc_sync, data_sync, ena_sync;
  logic                   rst_n_s, inc_s, data_s, ena_s;
  logic                   rst_n_d, inc_d;
  logic                   rst_n_rise, rst_n_fall, inc_rise;

  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [ADDR_W-1:0] shift_q, shift_nxt;
  logic [G_Y-1:0]    oh_q, oh_nxt;
  logic [BR_W-1:0]   br_nxt;
  logic              ovf_q, ovf_nxt;
  logic              addr_chg;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              um_ena_q, busy_q;

  // The clear pad synchroniser resets low so the selector starts in the cleared/framed state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_n_sync <= '0;
      inc_sync   <= '0;
      data_sync  <= '0;
      ena_sync   <= '0;
      rst_n_d    <= 1'b0;
      inc_d      <= 1'b0;
    end else begin
      rst_n_sync <= {rst_n_sync[SYNC_STAGES-2:0], bus.ctrl_sel_rst_n};
      inc_sync   <= {inc_sync[SYNC_STAGES-2:0],   bus.ctrl_sel_inc};
      data_sync  <= {data_sync[SYNC_STAGES-2:0],  bus.ctrl_sel_data};
      ena_sync   <= {ena_sync[SYNC_STAGES-2:0],   bus.ctrl_ena};
      rst_n_d    <= rst_n_s;
      inc_d      <= inc_s;
    end
  end

  assign rst_n_s    = rst_n_sync[SYNC_STAGES-1];
  assign inc_s      = inc_sync[SYNC_STAGES-1];
  assign data_s     = data_sync[SYNC_STAGES-1];
  assign ena_s      = ena_sync[SYNC_STAGES-1];
  assign rst_n_rise = rst_n_s & ~rst_n_d;
  assign rst_n_fall = ~rst_n_s & rst_n_d;
  assign inc_rise   = inc_s & ~inc_d;

  always_comb begin
    addr_nxt  = addr_q;
    ovf_nxt   = ovf_q;
    shift_nxt = shift_q;
    if (!bus.cfg_serial) begin
      // Clear wins over an increment seen in the same cycle.
      if (!rst_n_s) begin
        addr_nxt = '0;
        ovf_nxt  = 1'b0;
      end else if (inc_rise) begin
        if (addr_q == ADDR_LAST) begin
          addr_nxt = '0;
          ovf_nxt  = 1'b1;
        end else begin
          addr_nxt = addr_q + ADDR_W'(1);
        end
      end
    end else begin
      if (rst_n_fall) begin
        shift_nxt = '0;
      end else if (!rst_n_s && inc_rise) begin
        shift_nxt = {shift_q[ADDR_W-2:0], data_s};
      end
      if (rst_n_rise) begin
        if ({1'b0, shift_q} < N_DES) begin
          addr_nxt = shift_q;
          ovf_nxt  = 1'b0;
        end else begin
          ovf_nxt  = 1'b1;
        end
      end
    end
  end

  assign addr_chg = (addr_nxt != addr_q);
  assign br_nxt   = addr_nxt[ADDR_W-1:BLK_W];

  always_comb begin
    oh_nxt = '0;
    for (int i = 0; i < G_Y; i++) begin
      oh_nxt[i] = (br_nxt == BR_W'(i));
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (ena_s && !addr_chg) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_RELOAD;
        end
      end
      ST_GAP: begin
        if (!ena_s) begin
          state_nxt = ST_OFF;
        end else if (addr_chg) begin
          cnt_nxt = GAP_RELOAD;
        end else if (cnt_q == '0) begin
          state_nxt = ST_ON;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      ST_ON: begin
        if (!ena_s) begin
          state_nxt = ST_OFF;
        end else if (addr_chg) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_RELOAD;
        end
      end
      default: begin
        state_nxt = ST_OFF;
      end
    endcase
  end

  // um_ena is decoded from the next state so it drops on the very edge the address moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      shift_q  <= '0;
      oh_q     <= G_Y'(1);
      ovf_q    <= 1'b0;
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      um_ena_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      addr_q   <= addr_nxt;
      shift_q  <= shift_nxt;
      oh_q     <= oh_nxt;
      ovf_q    <= ovf_nxt;
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      um_ena_q <= (state_nxt == ST_ON);
      busy_q   <= (state_nxt == ST_GAP);
    end
  end

  assign bus.sel_addr      = addr_q;
  assign bus.sel_blk       = addr_q[BLK_W-1:0];
  assign bus.sel_branch_oh = oh_q;
  assign bus.sel_ovf       = ovf_q;
  assign bus.um_ena        = um_ena_q;
  assign bus.sel_busy      = busy_q;
endmodule
